seg_scan_mux: RTL

- Multiplexed N-digit 7-segment scanner. It sits directly downstream of the PIC32 parallel-bus capture logic.
- The CPU side writes one segment byte per digit through a valid/ready port. Each byte is ordered {a,b,c,d,e,f,g,dp}.
- The block time-slices the digits onto a shared segment bus, with a blanking gap between digits to suppress ghosting.
- Writes are tear-free: a write to the digit currently lit is held off until that digit goes dark.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/seg_scan_timer.sv | 53 +++++
 rtl/seg_scan_mux.sv | 100 ++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg_scan_pkg;

    typedef logic [7:0] seg_t;

    // Bit positions within seg_t, ordered {a,b,c,d,e,f,g,dp}
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam seg_t SEG_OFF = 8'h00;
    localparam int   PWM_W   = 4;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: counts cycles within a digit slot and advances the scanned digit on wrap.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic              clock,
    input  logic              reset_n,
    output scan_state_e       state,
    output logic              slot_wrap,
    output logic [PWM_W-1:0]  pwm,
    output logic [IDX_W-1:0]  scan_idx
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt_reg;
    logic [CNT_W-1:0] slot_cnt_next;
    logic [IDX_W-1:0] scan_idx_reg;
    logic [IDX_W-1:0] scan_idx_next;

    assign slot_wrap = (slot_cnt_reg == SLOT_LAST);

    always_comb begin
        slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
        scan_idx_next = scan_idx_reg;
        if (slot_wrap) begin
            scan_idx_next = (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_reg <= '0;
            scan_idx_reg <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_next;
            scan_idx_reg <= scan_idx_next;
        end
    end

    // State is a pure function of the slot position, so it is BLANK out of reset
    assign state    = (slot_cnt_reg < BLANK_END) ? BLANK : SHOW;
    assign pwm      = PWM_W'(slot_cnt_reg - BLANK_END);
    assign scan_idx = scan_idx_reg;

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed N-digit 7-segment scanner with tear-free pattern writes.
// Optional PWM dimming enabled by defining SEG_SCAN_MUX_BRIGHTNESS_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
    input  logic [7:0]                    wr_segments,
    output logic                          wr_ready,
    input  logic [3:0]                    brightness,
    output logic [7:0]                    seg,
    output logic [NUM_DIGITS-1:0]         digit_n
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    scan_state_e             state;
    logic                    slot_wrap;
    logic [PWM_W-1:0]        pwm;
    logic [IDX_W-1:0]        scan_idx;
    logic                    wr_fire;
    logic                    lit;
    logic                    unused_bits;
    logic [NUM_DIGITS-1:0]   wr_sel;
    logic [NUM_DIGITS-1:0]   digit_sel;
    seg_t                    pattern_reg [NUM_DIGITS];
    seg_t                    seg_reg;
    logic [NUM_DIGITS-1:0]   digit_n_reg;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .state     (state),
        .slot_wrap (slot_wrap),
        .pwm       (pwm),
        .scan_idx  (scan_idx)
    );

    // Only the digit currently lit is locked; every other pattern stays writable
    assign wr_ready = !((state == SHOW) && (wr_digit == scan_idx));
    assign wr_fire  = wr_valid && wr_ready;

    // Out-of-range indices match no select bit, so such writes are dropped
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign wr_sel[gi]    = wr_fire && (wr_digit == IDX_W'(gi));
            assign digit_sel[gi] = (scan_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pattern_reg[i] <= SEG_OFF;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_sel[i]) begin
                    pattern_reg[i] <= wr_segments;
                end
            end
        end
    end

`ifdef SEG_SCAN_MUX_BRIGHTNESS_EN
    assign lit         = (state == SHOW) && (pwm <= brightness);
    assign unused_bits = slot_wrap;
`else
    assign lit         = (state == SHOW);
    assign unused_bits = ^{brightness, pwm, slot_wrap};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_reg     <= SEG_OFF;
            digit_n_reg <= '1;
        end else if (lit) begin
            seg_reg     <= pattern_reg[scan_idx];
            digit_n_reg <= ~digit_sel;
        end else begin
            seg_reg     <= SEG_OFF;
            digit_n_reg <= '1;
        end
    end

    assign seg     = seg_reg;
    assign digit_n = digit_n_reg;

endmodule
